// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline latch with data-cache request handshake and branch resolution
module ex_mem #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic [WORD_W-1:0] aluout_in,
  input  logic              zero_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic [WORD_W-1:0] imm_in,
  input  logic [WORD_W-1:0] pcp4_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              branch_in,
  input  logic              branchSel_in,
  input  logic              regWrite_in,
  input  logic              MemtoReg_in,
  input  logic              halt_in,
  input  logic [4:0]        wsel_in,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dREN_out,
  output logic              dWEN_out,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] aluout_out,
  output logic [WORD_W-1:0] dload_out,
  output logic [WORD_W-1:0] pcp4_out,
  output logic              regWrite_out,
  output logic              MemtoReg_out,
  output logic              halt_out,
  output logic [4:0]        wsel_out,
  output logic              branch_taken,
  output logic [WORD_W-1:0] branch_target,
  output logic              stall_req
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state, next_state;
  logic   advance;
  assign stall_req = state == MEM_WAIT;
  assign advance   = state == IDLE && ihit;
  // state register; reset abandons any outstanding request
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end
  // flush beats advance; a memory op parks us in MEM_WAIT until dhit
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = (!flush && ihit && (dREN_in || dWEN_in)) ? MEM_WAIT : IDLE;
    else               next_state = dhit ? IDLE : MEM_WAIT;
  end
  // latch contents: clear on flush, capture on advance, retire request on dhit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dREN_out      <= 1'b0;
      dWEN_out      <= 1'b0;
      daddr         <= '0;
      dstore        <= '0;
      aluout_out    <= '0;
      dload_out     <= '0;
      pcp4_out      <= '0;
      regWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      halt_out      <= 1'b0;
      wsel_out      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else if (state == IDLE && flush) begin
      dREN_out      <= 1'b0;
      dWEN_out      <= 1'b0;
      daddr         <= '0;
      dstore        <= '0;
      aluout_out    <= '0;
      dload_out     <= '0;
      pcp4_out      <= '0;
      regWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      wsel_out      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else if (advance) begin
      dREN_out      <= dREN_in && !dWEN_in;
      dWEN_out      <= dWEN_in;
      daddr         <= aluout_in;
      dstore        <= rdat2_in;
      aluout_out    <= aluout_in;
      pcp4_out      <= pcp4_in;
      regWrite_out  <= regWrite_in;
      MemtoReg_out  <= MemtoReg_in;
      halt_out      <= halt_out || halt_in;
      wsel_out      <= wsel_in;
      branch_taken  <= branch_in && (zero_in ^ branchSel_in);
      branch_target <= pcp4_in + (imm_in << 2);
    end else if (state == MEM_WAIT && dhit) begin
      dREN_out  <= 1'b0;
      dWEN_out  <= 1'b0;
      dload_out <= dREN_out ? dmemload : dload_out;
    end
  end
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: randomized check of ex_mem against a transaction-level reference model
module tb_ex_mem;
  logic        CLK = 1'b0, nRST;
  logic        ihit, dhit, flush, zero_in, dREN_in, dWEN_in, branch_in, branchSel_in;
  logic        regWrite_in, MemtoReg_in, halt_in;
  logic [31:0] aluout_in, rdat2_in, imm_in, pcp4_in, dmemload;
  logic [4:0]  wsel_in;
  logic        dREN_out, dWEN_out, regWrite_out, MemtoReg_out, halt_out, branch_taken, stall_req;
  logic [31:0] daddr, dstore, aluout_out, dload_out, pcp4_out, branch_target;
  logic [4:0]  wsel_out;
  int checks = 0, failures = 0;
  logic        busy, e_dren, e_dwen, e_rw, e_m2r, e_halt, e_bk;
  logic [31:0] e_daddr, e_dstore, e_alu, e_dload, e_pcp4, e_bt;
  logic [4:0]  e_wsel;
  int          stalls;

  ex_mem dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .aluout_in(aluout_in), .zero_in(zero_in), .rdat2_in(rdat2_in), .imm_in(imm_in),
    .pcp4_in(pcp4_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .branch_in(branch_in),
    .branchSel_in(branchSel_in), .regWrite_in(regWrite_in), .MemtoReg_in(MemtoReg_in),
    .halt_in(halt_in), .wsel_in(wsel_in), .dmemload(dmemload),
    .dREN_out(dREN_out), .dWEN_out(dWEN_out), .daddr(daddr), .dstore(dstore),
    .aluout_out(aluout_out), .dload_out(dload_out), .pcp4_out(pcp4_out),
    .regWrite_out(regWrite_out), .MemtoReg_out(MemtoReg_out), .halt_out(halt_out),
    .wsel_out(wsel_out), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_req(stall_req)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_latch();
    e_dren = 0; e_dwen = 0; e_rw = 0; e_m2r = 0; e_bk = 0;
    e_daddr = 0; e_dstore = 0; e_alu = 0; e_dload = 0; e_pcp4 = 0; e_bt = 0; e_wsel = 0;
  endtask

  task automatic model_reset();
    clear_latch();
    busy = 0; e_halt = 0;
  endtask

  task automatic model_edge();
    if (!busy) begin
      if (flush) clear_latch();
      else if (ihit) begin
        e_alu = aluout_in; e_daddr = aluout_in; e_dstore = rdat2_in; e_pcp4 = pcp4_in;
        e_wsel = wsel_in; e_rw = regWrite_in; e_m2r = MemtoReg_in;
        e_halt = e_halt | halt_in;
        e_dwen = dWEN_in; e_dren = dREN_in & ~dWEN_in;
        e_bk = branch_in & (zero_in != branchSel_in);
        e_bt = pcp4_in + imm_in * 32'd4;
        busy = dREN_in | dWEN_in;
      end
    end else if (dhit) begin
      if (e_dren) e_dload = dmemload;
      e_dren = 0; e_dwen = 0; busy = 0;
    end
  endtask

  task automatic check_all();
    chk("stall_req", stall_req, busy);
    chk("dREN_out", dREN_out, e_dren);
    chk("dWEN_out", dWEN_out, e_dwen);
    chk("daddr", daddr, e_daddr);
    chk("dstore", dstore, e_dstore);
    chk("aluout_out", aluout_out, e_alu);
    chk("dload_out", dload_out, e_dload);
    chk("pcp4_out", pcp4_out, e_pcp4);
    chk("regWrite_out", regWrite_out, e_rw);
    chk("MemtoReg_out", MemtoReg_out, e_m2r);
    chk("halt_out", halt_out, e_halt);
    chk("wsel_out", wsel_out, e_wsel);
    chk("branch_taken", branch_taken, e_bk);
    chk("branch_target", branch_target, e_bt);
    chk("req_exclusive", dREN_out & dWEN_out, 1'b0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; flush = 0; zero_in = 0; dREN_in = 0; dWEN_in = 0; branch_in = 0;
    branchSel_in = 0; regWrite_in = 0; MemtoReg_in = 0; halt_in = 0;
    aluout_in = 0; rdat2_in = 0; imm_in = 0; pcp4_in = 0; dmemload = 0; wsel_in = 0;
  endtask

  task automatic rand_inputs();
    ihit = $urandom_range(0, 3) != 0;
    flush = $urandom_range(0, 7) == 0;
    dhit = $urandom_range(0, 2) == 0;
    dREN_in = $urandom_range(0, 3) == 0;
    dWEN_in = $urandom_range(0, 3) == 0;
    halt_in = $urandom_range(0, 99) == 0;
    {zero_in, branch_in, branchSel_in, regWrite_in, MemtoReg_in} = 5'($urandom);
    aluout_in = $urandom; rdat2_in = $urandom; imm_in = $urandom;
    pcp4_in = $urandom; dmemload = $urandom; wsel_in = 5'($urandom);
  endtask

  initial begin
    nRST = 0;
    idle_inputs();
    model_reset();
    #12;
    check_all();
    nRST = 1;
    cycle();
    // basic ALU writeback pass-through
    ihit = 1; regWrite_in = 1; aluout_in = 32'h10; wsel_in = 5'd5;
    cycle();
    chk("t33_alu", aluout_out, 32'h10);
    chk("t33_wsel", wsel_out, 5);
    chk("t33_rw", regWrite_out, 1);
    chk("t33_stall", stall_req, 0);
    // load with three wait cycles
    idle_inputs();
    ihit = 1; dREN_in = 1; aluout_in = 32'h100;
    stalls = 0;
    cycle();
    stalls += int'(stall_req);
    chk("t34_dren", dREN_out, 1);
    chk("t34_daddr", daddr, 32'h100);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      stalls += int'(stall_req);
    end
    chk("t34_stalls", stalls, 4);
    dhit = 1; dmemload = 32'hDEAD_BEEF;
    cycle();
    chk("t34_dload", dload_out, 32'hDEAD_BEEF);
    chk("t34_dren_clr", dREN_out, 0);
    chk("t34_idle", stall_req, 0);
    // flush and ihit ignored while waiting on a store
    idle_inputs();
    ihit = 1; dWEN_in = 1; aluout_in = 32'h200; rdat2_in = 32'h1234_5678;
    cycle();
    flush = 1; aluout_in = 32'h999; dWEN_in = 0;
    cycle();
    cycle();
    chk("t35_hold_addr", daddr, 32'h200);
    chk("t35_hold_wen", dWEN_out, 1);
    flush = 0; ihit = 0; dhit = 1;
    cycle();
    chk("t35_done", stall_req, 0);
    // taken branch with negative offset
    idle_inputs();
    ihit = 1; branch_in = 1; zero_in = 1; pcp4_in = 32'h40; imm_in = 32'hFFFF_FFFE;
    cycle();
    chk("t36_taken", branch_taken, 1);
    chk("t36_target", branch_target, 32'h38);
    // flush clears the latch but not a latched halt
    idle_inputs();
    ihit = 1; regWrite_in = 1; wsel_in = 5'd7; aluout_in = 32'h55;
    cycle();
    flush = 1;
    cycle();
    chk("t37_alu", aluout_out, 0);
    chk("t37_wsel", wsel_out, 0);
    flush = 0; halt_in = 1;
    cycle();
    chk("t37_halt", halt_out, 1);
    halt_in = 0; flush = 1;
    cycle();
    chk("t37_halt_sticky", halt_out, 1);
    // asynchronous reset mid-request
    idle_inputs();
    ihit = 1; dWEN_in = 1; aluout_in = 32'h300;
    cycle();
    idle_inputs();
    chk("t38_pre", dWEN_out, 1);
    #2 nRST = 0;
    #1;
    chk("t38_wen", dWEN_out, 0);
    chk("t38_stall", stall_req, 0);
    model_reset();
    check_all();
    nRST = 1;
    dhit = 1;
    cycle();
    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
      if (i % 400 == 399) begin
        nRST = 0;
        #1;
        model_reset();
        check_all();
        #1 nRST = 1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameter: WORD_W, 32, data/address width; fixed at 32 for this CPU.
REQ-002 CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 ihit  in  1  instruction-side hit; pipeline advance enable.
REQ-005 dhit  in  1  data-cache completion for the pending request.
REQ-006 flush  in  1  squash request from hazard/branch control.
REQ-007 aluout_in  in  32  execute ALU result (memory address or writeback value).
REQ-008 zero_in  in  1  ALU zero flag.
REQ-009 rdat2_in, imm_in, pcp4_in  in  32 each  store data, sign-extended immediate, PC+4.
REQ-010 dREN_in, dWEN_in, branch_in, branchSel_in, regWrite_in, MemtoReg_in, halt_in  in  1 each  control from the ID/EX latch.
REQ-011 wsel_in  in  5  destination register.
REQ-012 dmemload  in  32  data-cache read data.
REQ-013 dREN_out, dWEN_out  out  1  data-cache request strobes.
REQ-014 daddr, dstore  out  32  data-cache address and store data.
REQ-015 aluout_out, dload_out, pcp4_out  out  32  values for MEM/WB.
REQ-016 regWrite_out, MemtoReg_out, halt_out  out  1  control for MEM/WB; wsel_out  out  5.
REQ-017 branch_taken  out  1; branch_target  out  32  registered branch resolution.
REQ-018 stall_req  out  1  high while a data request is outstanding.

Function
REQ-019 The block SHALL have two states: IDLE and MEM_WAIT; stall_req SHALL equal (state==MEM_WAIT), combinationally.
REQ-020 advance SHALL be (state==IDLE && ihit); on advance with flush=0, all *_out registers SHALL capture their *_in counterparts, daddr<=aluout_in, dstore<=rdat2_in.
REQ-021 On advance, branch_taken SHALL capture branch_in & (zero_in XOR branchSel_in); branch_target SHALL capture pcp4_in + (imm_in<<2), 32-bit, carry discarded.
REQ-022 On advance with dREN_in|dWEN_in=1 and flush=0, state SHALL go IDLE->MEM_WAIT the same edge, with dREN_out/dWEN_out asserted from the next cycle.
REQ-023 In MEM_WAIT all outputs SHALL hold; ihit and flush SHALL be ignored.
REQ-024 In MEM_WAIT with dhit=1: dREN_out, dWEN_out SHALL clear, dload_out SHALL capture dmemload (reads only), state SHALL return to IDLE; earliest next advance is the following cycle.
REQ-025 In IDLE with flush=1 (with or without ihit): all control outputs, branch_taken and data outputs SHALL clear to 0, state stays IDLE; flush has priority over advance.
REQ-026 In IDLE without ihit and without flush, all registers SHALL hold.
REQ-027 halt_out, once 1, SHALL remain 1 until reset regardless of flush or advance.
REQ-028 dREN_out and dWEN_out SHALL never be 1 simultaneously; if both inputs are 1 on advance, dWEN wins.
REQ-029 dhit in IDLE SHALL be ignored.

Reset
REQ-030 nRST=0 SHALL asynchronously force state=IDLE and every output register to 0, including halt_out and branch_target.
REQ-031 Reset asserted in MEM_WAIT SHALL abandon the request: dREN_out/dWEN_out drop immediately.
REQ-032 After nRST rises, first advance SHALL require ihit on a rising edge.

Verification
REQ-033 Reset, then ihit=1, regWrite_in=1, aluout_in=0x0000_0010, wsel_in=5 -> next cycle aluout_out=0x10, wsel_out=5, regWrite_out=1, stall_req=0.
REQ-034 ihit=1, dREN_in=1, aluout_in=0x100; dhit low 3 cycles, then dhit=1, dmemload=0xDEAD_BEEF -> dREN_out=1, daddr=0x100, stall_req=1 for 4 cycles; then dload_out=0xDEADBEEF, dREN_out=0, state IDLE.
REQ-035 In MEM_WAIT apply flush=1 and ihit=1 -> no change; request completes on dhit.
REQ-036 branch_in=1, branchSel_in=0, zero_in=1, pcp4_in=0x40, imm_in=0xFFFF_FFFE -> branch_taken=1, branch_target=0x38.
REQ-037 Valid instruction latched, then flush=1 with ihit=1 -> all outputs 0 next cycle; halt_in=1 latched then flush -> halt_out stays 1.
REQ-038 nRST pulsed low mid-MEM_WAIT -> dWEN_out=0 without a clock edge, stall_req=0.
